// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the EG4S20 hard-ADC scan sequencer.
package adc_pkg;

    localparam int unsigned ADC_DW          = 12;
    localparam int unsigned ADC_SW          = 3;
    localparam int unsigned PWRUP_CYC_DEF   = 16;
    localparam int unsigned SETTLE_CYC_DEF  = 4;
    localparam int unsigned TIMEOUT_CYC_DEF = 255;
    localparam int unsigned CNT_W           = 16;

    typedef enum logic [2:0] {
        StIdle,
        StPwrup,
        StSettle,
        StSoc,
        StWait,
        StNext
    } scan_state_e;

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// Host-side control, adc_core hookup and result signals of the scan sequencer.
interface adc_scan_ctrl_if #(
    parameter int unsigned NCH = 8
);

    logic [NCH-1:0]             en_mask;
    logic                       start;
    logic                       cont;
    logic                       abort;
    logic                       busy;
    logic                       adc_pd;
    logic [adc_pkg::ADC_SW-1:0] adc_s;
    logic                       adc_soc;
    logic                       adc_eoc;
    logic [adc_pkg::ADC_DW-1:0] adc_dout;
    logic                       res_valid;
    logic [adc_pkg::ADC_SW-1:0] res_ch;
    logic [adc_pkg::ADC_DW-1:0] res_data;
    logic                       timeout_err;

    modport master (
        output en_mask, start, cont, abort, adc_eoc, adc_dout,
        input  busy, adc_pd, adc_s, adc_soc, res_valid, res_ch, res_data, timeout_err
    );

    modport slave (
        input  en_mask, start, cont, abort, adc_eoc, adc_dout,
        output busy, adc_pd, adc_s, adc_soc, res_valid, res_ch, res_data, timeout_err
    );

endinterface

// File: rtl/adc_ch_pick.sv
// Finds the lowest enabled channel, or the next enabled channel above cur_i.
module adc_ch_pick
    import adc_pkg::*;
#(
    parameter int unsigned NCH = 8
) (
    input  logic [NCH-1:0]    mask_i,
    input  logic [ADC_SW-1:0] cur_i,
    input  logic              from_low_i,
    output logic [ADC_SW-1:0] ch_o,
    output logic              found_o
);

    always_comb begin
        ch_o    = '0;
        found_o = 1'b0;
        // Descending walk so the lowest qualifying channel is the last one written.
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (mask_i[i] && (from_low_i || (i > int'(cur_i)))) begin
                ch_o    = ADC_SW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Scan sequencer for adc_core: walks an enable mask, averages 2^AVG_LOG2 samples per channel.
module adc_scan_ctrl
    import adc_pkg::*;
#(
    parameter int unsigned NCH         = 8,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned PWRUP_CYC   = PWRUP_CYC_DEF,
    parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic              clk,
    input logic              res,
    adc_scan_ctrl_if.slave   bus_io
);

    localparam int unsigned SMP_W = AVG_LOG2 + 1;
    localparam int unsigned ACC_W = ADC_DW + AVG_LOG2;
    localparam logic [SMP_W-1:0] NSMP = SMP_W'(1 << AVG_LOG2);

    scan_state_e       state_q;
    logic [NCH-1:0]    mask_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SMP_W-1:0]  smp_q;
    logic [ACC_W-1:0]  acc_q;
    logic              busy_q, adc_pd_q, adc_soc_q, res_valid_q, tmo_err_q;
    logic [ADC_SW-1:0] adc_s_q, res_ch_q;
    logic [ADC_DW-1:0] res_data_q;

    logic [ADC_SW-1:0] pick_ch, wrap_ch;
    logic              pick_found, wrap_found;
    logic [SMP_W-1:0]  smp_nxt;
    logic [ACC_W-1:0]  acc_sum;

    assign smp_nxt = smp_q + 1'b1;
    assign acc_sum = acc_q + ACC_W'(bus_io.adc_dout);

    // First channel after power-up, or the next one above the current channel.
    adc_ch_pick #(.NCH(NCH)) u_pick (
        .mask_i     (mask_q),
        .cur_i      (adc_s_q),
        .from_low_i (state_q == StPwrup),
        .ch_o       (pick_ch),
        .found_o    (pick_found)
    );

    // Lowest channel of the live mask, used when a continuous scan wraps.
    adc_ch_pick #(.NCH(NCH)) u_wrap (
        .mask_i     (bus_io.en_mask),
        .cur_i      ('0),
        .from_low_i (1'b1),
        .ch_o       (wrap_ch),
        .found_o    (wrap_found)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            cnt_q       <= '0;
            smp_q       <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            adc_pd_q    <= 1'b1;
            adc_s_q     <= '0;
            adc_soc_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            tmo_err_q   <= 1'b0;
        end else begin
            adc_soc_q   <= 1'b0;
            res_valid_q <= 1'b0;
            if (bus_io.abort && (state_q != StIdle)) begin
                state_q  <= StIdle;
                busy_q   <= 1'b0;
                adc_pd_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus_io.start && !bus_io.abort && (|bus_io.en_mask)) begin
                            mask_q    <= bus_io.en_mask;
                            tmo_err_q <= 1'b0;
                            busy_q    <= 1'b1;
                            adc_pd_q  <= 1'b0;
                            cnt_q     <= CNT_W'(PWRUP_CYC - 1);
                            state_q   <= StPwrup;
                        end
                    end
                    StPwrup: begin
                        if (cnt_q == '0) begin
                            adc_s_q <= pick_ch;
                            cnt_q   <= CNT_W'(SETTLE_CYC - 1);
                            state_q <= StSettle;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    StSettle: begin
                        if (cnt_q == '0) begin
                            acc_q     <= '0;
                            smp_q     <= '0;
                            adc_soc_q <= 1'b1;
                            state_q   <= StSoc;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    StSoc: begin
                        cnt_q   <= CNT_W'(TIMEOUT_CYC - 1);
                        state_q <= StWait;
                    end
                    StWait: begin
                        // An eoc on the final allowed cycle still wins over the timeout.
                        if (bus_io.adc_eoc) begin
                            acc_q <= acc_sum;
                            smp_q <= smp_nxt;
                            if (smp_nxt == NSMP) begin
                                res_valid_q <= 1'b1;
                                res_ch_q    <= adc_s_q;
                                res_data_q  <= ADC_DW'(acc_sum >> AVG_LOG2);
                                state_q     <= StNext;
                            end else begin
                                adc_soc_q <= 1'b1;
                                state_q   <= StSoc;
                            end
                        end else if (cnt_q == '0) begin
                            tmo_err_q <= 1'b1;
                            busy_q    <= 1'b0;
                            adc_pd_q  <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    StNext: begin
                        if (pick_found) begin
                            adc_s_q <= pick_ch;
                            cnt_q   <= CNT_W'(SETTLE_CYC - 1);
                            state_q <= StSettle;
                        end else if (bus_io.cont && wrap_found) begin
                            mask_q  <= bus_io.en_mask;
                            adc_s_q <= wrap_ch;
                            cnt_q   <= CNT_W'(SETTLE_CYC - 1);
                            state_q <= StSettle;
                        end else begin
                            busy_q   <= 1'b0;
                            adc_pd_q <= 1'b1;
                            state_q  <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus_io.busy        = busy_q;
    assign bus_io.adc_pd      = adc_pd_q;
    assign bus_io.adc_s       = adc_s_q;
    assign bus_io.adc_soc     = adc_soc_q;
    assign bus_io.res_valid   = res_valid_q;
    assign bus_io.res_ch      = res_ch_q;
    assign bus_io.res_data    = res_data_q;
    assign bus_io.timeout_err = tmo_err_q;

endmodule
